// File: rtl/npc_arb_pkg.sv
// Shared definitions for the 8-way request arbiter: FSM encodings and sizes.
package npc_arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    OWN   = 2'd2
  } arb_state_t;

  function automatic logic [N_REQ-1:0] id2onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/prio_rot8.sv
// Combinational priority search over 8 lines, descending from a start index
// (hp when rot=1, else 7) and wrapping 0->7.
module prio_rot8
  import npc_arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  logic [ID_W-1:0]  hp,
  input  logic             rot,
  output logic             hit,
  output logic [ID_W-1:0]  idx
);

  logic [ID_W-1:0]    start;
  logic [ID_W:0]      sh;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rotv;

  // Rotate so the start index lands on bit 7; then the highest set bit wins.
  assign start = rot ? hp : 3'd7;
  assign sh    = {1'b0, start} + 4'd1;
  assign dbl   = {vec, vec};
  assign rotv  = dbl[sh +: N_REQ];

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (rotv[j]) begin
        hit = 1'b1;
        idx = start + 3'(j) + 3'd1;
      end
    end
  end

endmodule

// File: rtl/arb8_ctrl.sv
// 8-requester arbiter with fixed/rotating priority, a valid/ready grant offer
// and an ownership phase released by done. All outputs are registered.
module arb8_ctrl
  import npc_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             rr_mode,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  output logic             gnt_valid,
  input  logic             gnt_ready,
  output logic [ID_W-1:0]  gnt_id,
  output logic [N_REQ-1:0] gnt_onehot,
  input  logic             done,
  output logic             busy
);

  arb_state_t       state, state_nxt;
  logic [ID_W-1:0]  hp, hp_nxt;
  logic [ID_W-1:0]  id_q, id_nxt;
  logic [N_REQ-1:0] oh_q, oh_nxt;
  logic             vld_q, vld_nxt;
  logic             busy_q, busy_nxt;
  logic [N_REQ-1:0] elig;
  logic             hit;
  logic [ID_W-1:0]  win;

  assign elig = req & ~mask;

  prio_rot8 u_prio (
    .vec (elig),
    .hp  (hp),
    .rot (rr_mode),
    .hit (hit),
    .idx (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hp     <= 3'd7;
      id_q   <= '0;
      oh_q   <= '0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      hp     <= hp_nxt;
      id_q   <= id_nxt;
      oh_q   <= oh_nxt;
      vld_q  <= vld_nxt;
      busy_q <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hp_nxt    = hp;
    id_nxt    = id_q;
    oh_nxt    = oh_q;
    vld_nxt   = vld_q;
    busy_nxt  = busy_q;
    case (state)
      IDLE: begin
        if (en && hit) begin
          state_nxt = OFFER;
          id_nxt    = win;
          oh_nxt    = id2onehot(win);
          vld_nxt   = 1'b1;
        end
      end
      // Offer is held regardless of req/mask until the consumer accepts it.
      OFFER: begin
        if (gnt_ready) begin
          state_nxt = OWN;
          vld_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          if (rr_mode) hp_nxt = id_q - 3'd1;
        end
      end
      OWN: begin
        if (done) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          oh_nxt    = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        vld_nxt   = 1'b0;
        busy_nxt  = 1'b0;
        oh_nxt    = '0;
      end
    endcase
  end

  assign gnt_valid  = vld_q;
  assign gnt_id     = id_q;
  assign gnt_onehot = oh_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_arb8_ctrl.sv
// Self-checking bench for arb8_ctrl: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_arb8_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, rr_mode, gnt_ready, done;
  logic [7:0] req, mask;
  logic       gnt_valid, busy;
  logic [2:0] gnt_id;
  logic [7:0] gnt_onehot;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a grant is either being offered, owned, or absent.
  bit m_offering, m_owning;
  int m_hp, m_id;

  always #5 clk = ~clk;

  arb8_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .rr_mode    (rr_mode),
    .req        (req),
    .mask       (mask),
    .gnt_valid  (gnt_valid),
    .gnt_ready  (gnt_ready),
    .gnt_id     (gnt_id),
    .gnt_onehot (gnt_onehot),
    .done       (done),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [7:0] e, input bit rr, input int hp);
    int start;
    start = rr ? hp : 7;
    for (int k = 0; k < 8; k++) begin
      int c;
      c = (start - k + 8) % 8;
      if (e[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_offering = 0;
    m_owning   = 0;
    m_hp       = 7;
    m_id       = 0;
  endtask

  task automatic model_clock();
    if (m_owning) begin
      if (done) m_owning = 0;
    end else if (m_offering) begin
      if (gnt_ready) begin
        m_offering = 0;
        m_owning   = 1;
        if (rr_mode) m_hp = (m_id + 7) % 8;
      end
    end else if (en) begin
      int w;
      w = model_pick(req & ~mask, rr_mode, m_hp);
      if (w >= 0) begin
        m_offering = 1;
        m_id       = w;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] exp_oh;
    exp_oh = (m_offering || m_owning) ? (8'h01 << m_id) : 8'h00;
    check({tag, ".valid"}, gnt_valid, m_offering);
    check({tag, ".busy"}, busy, m_owning);
    check({tag, ".id"}, gnt_id, m_id);
    check({tag, ".onehot"}, gnt_onehot, exp_oh);
  endtask

  task automatic step(input string tag, input logic e, input logic rr, input logic [7:0] r,
                      input logic [7:0] m, input logic rdy, input logic d);
    en = e; rr_mode = rr; req = r; mask = m; gnt_ready = rdy; done = d;
    @(posedge clk);
    model_clock();
    #1;
    check_outputs(tag);
  endtask

  int seq35 [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

  initial begin
    rst_n = 1'b0; en = 0; rr_mode = 0; req = 0; mask = 0; gnt_ready = 0; done = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed priority picks the highest eligible index.
    step("fix_arb", 1, 0, 8'h26, 8'h00, 0, 0);
    check("fix_id5", gnt_id, 3'd5);
    check("fix_oh20", gnt_onehot, 8'h20);
    check("fix_vld", gnt_valid, 1'b1);
    step("fix_acc", 1, 0, 8'h26, 8'h00, 1, 0);
    step("fix_done", 1, 0, 8'h00, 8'h00, 0, 1);

    // Rotating priority walks down and wraps.
    for (int i = 0; i < 9; i++) begin
      step("rr_arb", 1, 1, 8'hFF, 8'h00, 0, 0);
      check($sformatf("rr_seq%0d", i), gnt_id, seq35[i]);
      step("rr_acc", 1, 1, 8'hFF, 8'h00, 1, 0);
      step("rr_done", 1, 1, 8'hFF, 8'h00, 0, 1);
    end

    // Offer held stable while req changes and ready stays low.
    step("hold_arb", 1, 0, 8'hFF, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step("hold", 1, 0, 8'h01, 8'h00, 0, 1);
      check("hold_id", gnt_id, 3'd7);
      check("hold_vld", gnt_valid, 1'b1);
    end
    step("hold_acc", 1, 0, 8'h01, 8'h00, 1, 0);
    step("hold_done", 1, 0, 8'h00, 8'h00, 0, 1);

    // Mask applied during ownership steers the next arbitration.
    step("msk_arb", 1, 0, 8'h08, 8'h00, 0, 0);
    check("msk_id3", gnt_id, 3'd3);
    step("msk_acc", 1, 0, 8'h08, 8'h00, 1, 0);
    step("msk_own", 1, 0, 8'h08, 8'h08, 0, 0);
    step("msk_done", 1, 0, 8'h0C, 8'h08, 0, 1);
    step("msk_arb2", 1, 0, 8'h0C, 8'h08, 0, 0);
    check("msk_id2", gnt_id, 3'd2);
    check("msk_vld", gnt_valid, 1'b1);
    step("msk_acc2", 1, 0, 8'h0C, 8'h08, 1, 0);
    step("msk_done2", 1, 0, 8'h00, 8'h00, 0, 1);

    // Enable low blocks arbitration only.
    for (int i = 0; i < 10; i++) begin
      step("en_off", 0, 0, 8'hFF, 8'h00, 1, 1);
      check("en_off_vld", gnt_valid, 1'b0);
    end
    step("en_on", 1, 0, 8'hFF, 8'h00, 0, 0);
    check("en_on_vld", gnt_valid, 1'b1);
    step("en_acc", 0, 0, 8'hFF, 8'h00, 1, 0);
    step("en_own", 0, 0, 8'hFF, 8'h00, 0, 0);

    // Asynchronous reset in the middle of ownership.
    check("pre_rst_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_busy", busy, 1'b0);
    check("arst_oh", gnt_onehot, 8'h00);
    check("arst_vld", gnt_valid, 1'b0);
    #2;
    rst_n = 1'b1;
    step("post_rst", 1, 1, 8'hFF, 8'h00, 0, 0);
    check("post_rst_hp7", gnt_id, 3'd7);
    step("post_acc", 1, 1, 8'hFF, 8'h00, 1, 0);
    step("post_done", 1, 1, 8'h00, 8'h00, 0, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic e, rr, rdy, d;
      logic [7:0] r, m;
      e   = ($urandom_range(3) != 0);
      rr  = ($urandom_range(7) != 0) ? ((i / 500) % 2 == 0) : $urandom_range(1);
      r   = 8'($urandom);
      m   = 8'($urandom) & 8'($urandom);
      rdy = $urandom_range(1);
      d   = ($urandom_range(4) < 2);
      step("rand", e, rr, r, m, rdy, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arb8_ctrl.md
ARB8_CTRL -- requirements
Module: arb8_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: en  input  1  arbitration enable; low blocks new arbitration only.
REQ-004 SHALL have ports: rr_mode  input  1  0 = fixed priority (index 7 highest), 1 = rotating priority.
REQ-005 SHALL have ports: req  input  8  per-requester request, level-sensitive.
REQ-006 SHALL have ports: mask  input  8  1 = requester ineligible.
REQ-007 SHALL have ports: gnt_valid  output  1  grant offered.
REQ-008 SHALL have ports: gnt_ready  input  1  consumer accepts offered grant.
REQ-009 SHALL have ports: gnt_id  output  3  winning index, registered.
REQ-010 SHALL have ports: gnt_onehot  output  8  one-hot of gnt_id, zero when no grant is held.
REQ-011 SHALL have ports: done  input  1  granted owner releases resource.
REQ-012 SHALL have ports: busy  output  1  grant accepted and resource owned.

Function
REQ-013 SHALL implement FSM states IDLE, OFFER, OWN.
REQ-014 Eligible vector SHALL be req & ~mask; arbitration SHALL occur only in IDLE with en=1 and eligible nonzero.
REQ-015 IDLE->OFFER on arbitration; winner SHALL be registered into gnt_id, with gnt_valid=1 in the next cycle (1-cycle latency).
REQ-016 Fixed mode SHALL select the highest set eligible index.
REQ-017 Rotating mode SHALL search downward from register hp (wrapping 0->7) and select the first set eligible index.
REQ-018 On acceptance of winner k in rotating mode, hp SHALL become (k-1) mod 8; k=0 SHALL give hp=7.
REQ-019 hp SHALL NOT change in fixed mode.
REQ-020 OFFER: gnt_valid=1 and gnt_id/gnt_onehot SHALL be held stable until gnt_ready=1; then the FSM SHALL go to OWN.
REQ-021 A grant, once offered, SHALL NOT be retracted; req or mask changes during OFFER SHALL be ignored.
REQ-022 OWN: busy=1, gnt_valid=0, gnt_onehot SHALL be held.
REQ-023 OWN: done=1 SHALL go to IDLE with gnt_onehot=0 and busy=0 next cycle.
REQ-024 done outside OWN SHALL be ignored; gnt_ready outside OFFER SHALL be ignored.
REQ-025 en=0 during OFFER/OWN SHALL NOT abort the transaction; IDLE SHALL wait.
REQ-026 Requests present on the done cycle SHALL be arbitrated in the following IDLE cycle; minimum grant-to-grant spacing SHALL be 1 IDLE cycle.
REQ-027 Outputs SHALL be driven from registers only; no combinational path from req/mask to any output.

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE, hp=7, gnt_id=0, gnt_onehot=0, gnt_valid=0, busy=0.
REQ-029 Reset mid-OFFER or mid-OWN SHALL drop the grant immediately; no release handshake is required.
REQ-030 Reset release SHALL take effect synchronously at the first clk edge after rst_n rises.

Structure
REQ-031 Shared package/header npc_arb_pkg SHALL hold the state encodings (IDLE=2'd0, OFFER=2'd1, OWN=2'd2), N_REQ=8 and ID_W=3.
REQ-032 The rotating priority search SHALL be a combinational sub-module prio_rot8 (inputs vec[7:0], hp[2:0], rot; outputs hit, idx[2:0]).
REQ-033 Unused state encoding 2'd3 SHALL recover to IDLE.

Verification
REQ-034 Fixed mode, req=8'b0010_0110, mask=0, en=1 -> gnt_valid next cycle, gnt_id=5, gnt_onehot=8'h20.
REQ-035 Rotating mode, all 8 requesting, gnt_ready=1 and done pulsed each grant -> gnt_id sequence 7,6,5,4,3,2,1,0,7 (wrap).
REQ-036 gnt_ready held 0 for 5 cycles while req changes to 8'h01 -> gnt_id stays at original winner and gnt_valid stays 1 throughout.
REQ-037 Requester 3 granted, mask[3] set during OWN, then done with req=8'h0C -> next grant = 2.
REQ-038 rst_n asserted mid-OWN, asynchronous to clk -> busy=0 and gnt_onehot=0 before the next clk edge; hp=7 after release.
REQ-039 en=0 with req=8'hFF -> gnt_valid stays 0 indefinitely; en raised -> grant in next cycle.
